// File: rtl/elastic_pipe_buf.sv
// elastic_pipe_buf: FWFT valid/ready buffer between datapath stages.
// Registered ready/valid decode; flush drops buffered words.
module elastic_pipe_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Handshake decode from registered count only.
    always_comb begin
        in_ready  = (count != CW'(DEPTH)) & ~rst;
        out_valid = (count != '0) & ~rst;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = mem[rd_ptr];
    end

    // Storage: cleared on reset, untouched by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; flush realigns read to write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_pipe_buf.sv
// tb_elastic_pipe_buf: randomized scoreboard bench for elastic_pipe_buf.
// A queue model tracks expected contents; a negedge monitor checks outputs.
module tb_elastic_pipe_buf;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    elastic_pipe_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;
    int cycle       = 0;

    logic [WIDTH-1:0] q[$];
    bit               armed      = 0;
    bit               prev_stall = 0;
    bit               prev_rst   = 0;
    logic [WIDTH-1:0] prev_data  = '0;
    bit               rand_rdy   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cycle++;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom % 2);
    end

    // Monitor: compare DUT against queue model, then advance the model
    // by the handshakes that the coming edge will perform.
    always @(negedge clk) begin
        bit exp_rdy;
        bit exp_vld;
        if (!armed && rst === 1'b1) armed = 1;
        if (armed) begin
            exp_rdy = (q.size() != DEPTH) && !rst;
            exp_vld = (q.size() != 0) && !rst;
            check("count", 32'(count), 32'(q.size()));
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(exp_vld));
            if (exp_vld) check("out_data", 32'(out_data), 32'(q[0]));
            if (prev_stall && exp_vld)
                check("stall_stable", 32'(out_data), 32'(prev_data));
            if (prev_rst && !rst)
                check("rst_data", 32'(out_data), 32'(0));
            prev_stall = exp_vld && !out_ready && !rst && !flush;
            prev_data  = out_data;
            prev_rst   = rst;
            if (rst || flush) begin
                q.delete();
            end else begin
                if (exp_vld && out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (in_valid && exp_rdy) q.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        tick();
        check("drained", 32'(q.size()), 32'(0));
    endtask

    initial begin
        int t0;
        int p0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // single word
        send(16'h0001);
        tick();
        p0 = pops;
        drain();
        check("t1_pops", 32'(pops - p0), 32'(1));

        // fill, hold, release
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(WIDTH'(i));
        in_valid = 1'b1;
        in_data  = 16'h0005;
        repeat (3) tick();
        out_ready = 1'b1;
        send(16'h0005);
        p0 = pops;
        drain();
        check("t2_pops", 32'(pops - p0) >= 32'(1), 32'(1));

        // streaming
        out_ready = 1'b1;
        t0 = cycle;
        for (int i = 0; i < 20; i++) send(WIDTH'(i));
        check("t3_rate", 32'(cycle - t0), 32'(20));
        drain();

        // random backpressure across wrap
        rand_rdy = 1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom % 4 == 0) tick();
            send(WIDTH'($urandom));
        end
        rand_rdy = 0;
        tick();
        drain();

        // flush
        out_ready = 1'b0;
        send(16'h000A);
        send(16'h000B);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h000C;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        send(16'h000D);
        p0 = pops;
        drain();
        check("t5_pops", 32'(pops - p0), 32'(1));

        // reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(WIDTH'(16'h0100 + i));
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0777;
        out_ready = 1'b1;
        repeat (2) tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        p0 = pops;
        repeat (5) tick();
        check("t6_no_stale", 32'(pops - p0), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
